// File: rtl/filter_mem_pkg.sv
// Shared types and helpers for the filter processor data memory.
// Holds the loader state encoding, datapath widths and the address range test.
package filter_mem_pkg;

    localparam int DATA_W      = 8;
    localparam int PROC_ADDR_W = 32;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LOAD = 2'd1,
        LDR_DONE = 2'd2
    } ldr_state_e;

    // An address is in range when every bit above the physical width is zero.
    function automatic logic addr_in_range(input logic [PROC_ADDR_W-1:0] addr,
                                           input int unsigned            addr_bits);
        logic [PROC_ADDR_W-1:0] hi;
        hi = addr >> addr_bits;
        return (hi == '0);
    endfunction

endpackage

// File: rtl/filter_ram_core.sv
// Single-port synchronous byte array with a registered read port and an
// optional second output register (RD_LATENCY == 2).
// Read data holds its last value between reads; contents are never reset.
module filter_ram_core
    import filter_mem_pkg::*;
#(
    parameter int ADDR_BITS  = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic                 rd_zero_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o,
    output logic                 rvalid_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd1_q;
    logic              rv1_q;

    // Array write; no reset so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // First read stage; an out-of-range read returns zero instead of aliasing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q <= '0;
            rv1_q <= 1'b0;
        end else begin
            rv1_q <= re_i;
            if (re_i) begin
                rd1_q <= rd_zero_i ? '0 : mem_q[addr_i];
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_oreg
            logic [DATA_W-1:0] rd2_q;
            logic              rv2_q;

            // Output register stage; only a valid first stage updates the data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd2_q <= '0;
                    rv2_q <= 1'b0;
                end else begin
                    rv2_q <= rv1_q;
                    if (rv1_q) begin
                        rd2_q <= rd1_q;
                    end
                end
            end

            assign rdata_o  = rd2_q;
            assign rvalid_o = rv2_q;
        end else begin : g_noreg
            assign rdata_o  = rd1_q;
            assign rvalid_o = rv1_q;
        end
    endgenerate

endmodule

// File: rtl/filter_data_ram.sv
// Filter processor data memory: processor request port plus a host image
// loader. The processor always wins the single array port; the loader only
// accepts a byte in a cycle with no processor request.
// Optional build macro FILTER_RAM_STATS_EN adds rd_count / wr_count outputs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LDR_IDLE | loader inactive, load_ready low
// LDR_LOAD | accepting host bytes at the load pointer
// LDR_DONE | last byte written, load_done high for this one cycle
module filter_data_ram
    import filter_mem_pkg::*;
#(
    parameter int          ADDR_BITS  = 16,
    parameter int unsigned LOAD_BASE  = 0,
    parameter int          RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_RE_RAM,
    input  logic                   mem_WE_RAM,
    input  logic [PROC_ADDR_W-1:0] Data_Dir_RAM,
    input  logic [DATA_W-1:0]      Data_RAM,
    output logic [DATA_W-1:0]      Data_in_RAM,
    output logic                   rd_valid,
    output logic                   addr_err,
    input  logic                   load_start,
    input  logic                   load_valid,
    input  logic [DATA_W-1:0]      load_data,
    input  logic                   load_last,
    output logic                   load_ready,
    output logic                   load_done
`ifdef FILTER_RAM_STATS_EN
   ,output logic [31:0]            rd_count,
    output logic [31:0]            wr_count
`endif
);

    localparam logic [ADDR_BITS-1:0] PTR_BASE = LOAD_BASE[ADDR_BITS-1:0];
    localparam logic [ADDR_BITS-1:0] PTR_LAST = '1;

    ldr_state_e           state_q;
    logic [ADDR_BITS-1:0] ptr_q;
    logic                 load_done_q;
    logic                 addr_err_q;

    logic                 proc_acc;
    logic                 in_range;
    logic                 rd_issue;
    logic                 ld_hs;
    logic                 core_we;
    logic [ADDR_BITS-1:0] core_addr;
    logic [DATA_W-1:0]    core_wdata;

    assign proc_acc   = mem_RE_RAM | mem_WE_RAM;
    assign in_range   = addr_in_range(Data_Dir_RAM, ADDR_BITS);
    // A simultaneous write suppresses the read entirely.
    assign rd_issue   = mem_RE_RAM & ~mem_WE_RAM;
    assign load_ready = (state_q == LDR_LOAD) & ~proc_acc;
    assign ld_hs      = load_valid & load_ready;

    assign core_we    = (mem_WE_RAM & in_range) | ld_hs;
    assign core_addr  = proc_acc ? Data_Dir_RAM[ADDR_BITS-1:0] : ptr_q;
    assign core_wdata = mem_WE_RAM ? Data_RAM : load_data;

    filter_ram_core #(
        .ADDR_BITS  (ADDR_BITS),
        .RD_LATENCY (RD_LATENCY)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (core_we),
        .re_i      (rd_issue),
        .rd_zero_i (~in_range),
        .addr_i    (core_addr),
        .wdata_i   (core_wdata),
        .rdata_o   (Data_in_RAM),
        .rvalid_o  (rd_valid)
    );

    // Loader FSM; load_done is registered and coincides with LDR_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LDR_IDLE;
            ptr_q       <= PTR_BASE;
            load_done_q <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            if (load_start) begin
                state_q <= LDR_LOAD;
                ptr_q   <= PTR_BASE;
            end else begin
                case (state_q)
                    LDR_LOAD: begin
                        if (ld_hs) begin
                            if (load_last || (ptr_q == PTR_LAST)) begin
                                state_q     <= LDR_DONE;
                                load_done_q <= 1'b1;
                            end
                            // The pointer parks at the top byte rather than wrapping.
                            if (ptr_q != PTR_LAST) begin
                                ptr_q <= ptr_q + 1'b1;
                            end
                        end
                    end
                    LDR_DONE: state_q <= LDR_IDLE;
                    default:  state_q <= LDR_IDLE;
                endcase
            end
        end
    end

    assign load_done = load_done_q;

    // Sticky range error; a fresh error in the same cycle outranks the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else if (proc_acc && !in_range) begin
            addr_err_q <= 1'b1;
        end else if (load_start) begin
            addr_err_q <= 1'b0;
        end
    end

    assign addr_err = addr_err_q;

`ifdef FILTER_RAM_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    // Saturating access counters; out-of-range accesses count, loader writes do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (load_start) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_issue && (rd_cnt_q != '1)) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
            if (mem_WE_RAM && (wr_cnt_q != '1)) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_filter_data_ram.sv
// Self-checking bench for filter_data_ram against a cycle-level reference model.
// Build with FILTER_RAM_STATS_EN defined to also exercise the access counters.
module tb_filter_data_ram;

    localparam int AB    = 16;
    localparam int LAT   = 1;
    localparam int BASE  = 0;
    localparam int DEPTH = 1 << AB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_RE_RAM = 1'b0;
    logic        mem_WE_RAM = 1'b0;
    logic [31:0] Data_Dir_RAM = '0;
    logic [7:0]  Data_RAM = '0;
    logic [7:0]  Data_in_RAM;
    logic        rd_valid;
    logic        addr_err;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        load_done;
`ifdef FILTER_RAM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    always #5 clk = ~clk;

    filter_data_ram #(
        .ADDR_BITS  (AB),
        .LOAD_BASE  (BASE),
        .RD_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_RE_RAM   (mem_RE_RAM),
        .mem_WE_RAM   (mem_WE_RAM),
        .Data_Dir_RAM (Data_Dir_RAM),
        .Data_RAM     (Data_RAM),
        .Data_in_RAM  (Data_in_RAM),
        .rd_valid     (rd_valid),
        .addr_err     (addr_err),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .load_done    (load_done)
`ifdef FILTER_RAM_STATS_EN
       ,.rd_count     (rd_count),
        .wr_count     (wr_count)
`endif
    );

    // reference model state
    logic [7:0]  m_mem [DEPTH];
    bit          m_kn  [DEPTH];
    int          m_st;          // 0 idle, 1 loading, 2 done
    int          m_ptr;
    bit          m_err;
    bit          m_done;
    bit          m_v;
    logic [7:0]  m_d;
    bit          m_dk;
    bit          q_v[$];
    logic [7:0]  q_d[$];
    bit          q_k[$];
    logic [31:0] m_rdc;
    logic [31:0] m_wrc;

    int n_chk = 0;
    int n_bad = 0;
    bit done_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        m_st   = 0;
        m_ptr  = BASE;
        m_err  = 0;
        m_done = 0;
        m_v    = 0;
        m_d    = 8'h00;
        m_dk   = 1;
        m_rdc  = '0;
        m_wrc  = '0;
        q_v.delete();
        q_d.delete();
        q_k.delete();
        for (int i = 0; i < LAT - 1; i++) begin
            q_v.push_back(1'b0);
            q_d.push_back(8'h00);
            q_k.push_back(1'b1);
        end
    endtask

    // Advance one clock with the inputs already driven; model and compare.
    task automatic tick();
        bit         acc, inr, rdi, hs, kn, nv, nk;
        logic [7:0] rdv, nd;
        int         a_lo;
        #1;
        acc  = mem_RE_RAM || mem_WE_RAM;
        inr  = ((Data_Dir_RAM >> AB) == 32'd0);
        a_lo = int'(Data_Dir_RAM & (DEPTH - 1));
        chk("load_ready", load_ready, (m_st == 1) && !acc);
        hs   = load_valid && (m_st == 1) && !acc;
        rdi  = mem_RE_RAM && !mem_WE_RAM;
        rdv  = 8'h00;
        kn   = 1;
        if (rdi && inr) begin
            rdv = m_mem[a_lo];
            kn  = m_kn[a_lo];
        end
        if (mem_WE_RAM && inr) begin
            m_mem[a_lo] = Data_RAM;
            m_kn[a_lo]  = 1;
        end
        q_v.push_back(rdi);
        q_d.push_back(rdv);
        q_k.push_back(kn);
        nv = q_v.pop_front();
        nd = q_d.pop_front();
        nk = q_k.pop_front();
        m_v = nv;
        if (nv) begin
            m_d  = nd;
            m_dk = nk;
        end
        if (acc && !inr)     m_err = 1;
        else if (load_start) m_err = 0;
        if (load_start) begin
            m_rdc = '0;
            m_wrc = '0;
        end else begin
            if (rdi && m_rdc != 32'hFFFF_FFFF) m_rdc = m_rdc + 1;
            if (mem_WE_RAM && m_wrc != 32'hFFFF_FFFF) m_wrc = m_wrc + 1;
        end
        if (load_start) begin
            m_st  = 1;
            m_ptr = BASE;
        end else if (m_st == 1) begin
            if (hs) begin
                m_mem[m_ptr] = load_data;
                m_kn[m_ptr]  = 1;
                if (load_last || m_ptr == DEPTH - 1) m_st = 2;
                else                                 m_ptr++;
            end
        end else if (m_st == 2) begin
            m_st = 0;
        end
        m_done = (m_st == 2);
        @(posedge clk);
        #1;
        chk("rd_valid", rd_valid, m_v);
        if (m_dk) chk("rd_data", Data_in_RAM, m_d);
        chk("addr_err", addr_err, m_err);
        chk("load_done", load_done, m_done);
        if (load_done) done_seen = 1;
`ifdef FILTER_RAM_STATS_EN
        chk("rd_count", rd_count, m_rdc);
        chk("wr_count", wr_count, m_wrc);
`endif
    endtask

    task automatic cyc(input bit re, input bit we, input logic [31:0] a, input logic [7:0] d,
                       input bit ls, input bit lv, input logic [7:0] ld, input bit ll);
        mem_RE_RAM   = re;
        mem_WE_RAM   = we;
        Data_Dir_RAM = a;
        Data_RAM     = d;
        load_start   = ls;
        load_valid   = lv;
        load_data    = ld;
        load_last    = ll;
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        cyc(0, 1, a, d, 0, 0, 8'h00, 0);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1, 0, a, 8'h00, 0, 0, 8'h00, 0);
    endtask

    task automatic nop();
        cyc(0, 0, 32'h0, 8'h00, 0, 0, 8'h00, 0);
    endtask

    task automatic lstart();
        cyc(0, 0, 32'h0, 8'h00, 1, 0, 8'h00, 0);
    endtask

    initial begin
        int i;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",  Data_in_RAM, 8'h00);
        chk("rst_valid", rd_valid, 0);
        chk("rst_err",   addr_err, 0);
        chk("rst_ready", load_ready, 0);
        chk("rst_done",  load_done, 0);
        rst_n = 1'b1;

        // basic write then read, read-after-write
        wr(32'h10, 8'hA5);
        rd(32'h10);
        nop();

        // out-of-range read, sticky error, cleared by load_start
        rd(32'h0001_0000);
        nop();
        nop();
        lstart();
        nop();

        // simultaneous RE and WE: write wins, no read
        cyc(1, 1, 32'h20, 8'h3C, 0, 0, 8'h00, 0);
        rd(32'h20);
        nop();

        // load with processor contention on cycles 3-4
        lstart();
        i = 0;
        for (int c = 0; c < 40 && i < 8; c++) begin
            bit re, ok;
            re = (c == 3 || c == 4);
            ok = (m_st == 1) && !re;
            cyc(re, 0, 32'h10, 8'h00, 0, 1, 8'(i), (i == 7));
            if (ok) i++;
        end
        nop();
        for (int k = 0; k < 8; k++) rd(32'(k));
        nop();

        // asynchronous reset in the middle of a load
        lstart();
        for (int k = 0; k < 3; k++) cyc(0, 0, 32'h0, 8'h00, 0, 1, 8'(8'hC0 + k), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data",  Data_in_RAM, 8'h00);
        chk("arst_valid", rd_valid, 0);
        chk("arst_err",   addr_err, 0);
        chk("arst_ready", load_ready, 0);
        chk("arst_done",  load_done, 0);
        mdl_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) rd(32'(k));
        nop();

        // randomized mix of processor traffic and loader activity
        for (int n = 0; n < 600; n++) begin
            int          r;
            bit          re, we, ls, lv, ll;
            logic [31:0] a;
            r  = $urandom_range(0, 9);
            re = 0;
            we = 0;
            a  = 32'($urandom_range(0, 63));
            case (r)
                0, 1, 2: we = 1;
                3, 4, 5: re = 1;
                6: begin re = 1; a = 32'h0001_0000 + ($urandom & 32'h00FF_FFFF); end
                7: begin re = 1; we = 1; end
                8: begin we = 1; a = 32'h8000_0000 | $urandom; end
                default: ;
            endcase
            lv = $urandom_range(0, 1) == 1;
            ls = !lv && ($urandom_range(0, 29) == 0);
            ll = $urandom_range(0, 7) == 0;
            cyc(re, we, a, 8'($urandom), ls, lv, 8'($urandom), ll);
        end
        nop();

`ifdef FILTER_RAM_STATS_EN
        lstart();
        for (int k = 0; k < 5; k++) rd(32'(k));
        for (int k = 0; k < 3; k++) wr(32'(k + 40), 8'(k));
        rd(32'h0002_0000);
        chk("stats_rd6", rd_count, 32'd6);
        chk("stats_wr3", wr_count, 32'd3);
        lstart();
        chk("stats_rd_clr", rd_count, 32'd0);
        chk("stats_wr_clr", wr_count, 32'd0);
`endif

        // stream past the top address without load_last
        lstart();
        done_seen = 0;
        for (int k = 0; k < DEPTH + 8 && m_st == 1; k++) begin
            cyc(0, 0, 32'h0, 8'h00, 0, 1, 8'(k) ^ 8'h5A, 0);
        end
        nop();
        chk("ptr_end_done_seen", done_seen, 1);
        rd(32'h0000_FFFF);
        rd(32'h0000_FFFE);
        rd(32'h0000_0000);
        nop();

        // restart while loading: next byte lands at LOAD_BASE
        lstart();
        for (int k = 0; k < 3; k++) cyc(0, 0, 32'h0, 8'h00, 0, 1, 8'h70 + 8'(k), 0);
        lstart();
        cyc(0, 0, 32'h0, 8'h00, 0, 1, 8'hEE, 1);
        nop();
        rd(32'(BASE));
        rd(32'(BASE + 1));
        nop();
        chk("restart_byte", Data_in_RAM, 8'h71);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
